// File: rtl/proc_mem_responder.sv
// proc_mem_responder: memory-side responder for the TinyRV1 pipelined processor.
// One word-addressed array is shared by the imem (fetch) port and the dmem (LW/SW) port.
// Every request gets exactly one response LAT cycles after it is accepted.
// Optional feature macro: MEM_MMIO_EN adds a 16-byte MMIO window at MMIO_BASE
// (write MMIO_BASE+0 -> mmio_out, read MMIO_BASE+4 <- mmio_in).
// The MMIO window is matched on addr[31:4], so MMIO_BASE is expected to be 16-byte aligned.
module proc_mem_responder #(
    parameter int          WORDS     = 256,
    parameter int          LAT       = 1,
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    output logic [31:0] imemresp_rdata,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    output logic [31:0] dmemresp_rdata,
    input  logic [31:0] mmio_in,
    output logic [31:0] mmio_out,
    output logic        mmio_out_val,
    output logic        err
);
    localparam int AW = $clog2(WORDS);

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("proc_mem_responder: LAT must be in 1..4");
    end
    if (WORDS < 16 || WORDS > 4096 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
        $error("proc_mem_responder: WORDS must be a power of 2 in 16..4096");
    end

    // Storage is deliberately not reset: contents survive rst.
    logic [31:0] mem [WORDS];

    logic [AW-1:0] i_idx, d_idx;
    logic          i_ok, d_ok;           // aligned and inside the array
    logic          i_win, d_win;         // address falls in the MMIO window
    logic          d_mi_sel;             // dmem read of the mmio_in register
    logic          i_legal, d_legal;
    logic          i_bad, d_bad, d_wr;
    logic [31:0]   i_rd0, d_rd0;         // response data captured at the accepting edge

    assign i_idx = imemreq_addr[2 +: AW];
    assign d_idx = dmemreq_addr[2 +: AW];
    assign i_ok  = (imemreq_addr[1:0] == 2'b00) && (imemreq_addr[31:2+AW] == '0);
    assign d_ok  = (dmemreq_addr[1:0] == 2'b00) && (dmemreq_addr[31:2+AW] == '0);

`ifdef MEM_MMIO_EN
    logic mo_wr;

    // imem never sees MMIO; a fetch there is treated as out of range.
    assign i_win    = imemreq_addr[31:4] == MMIO_BASE[31:4];
    assign d_win    = dmemreq_addr[31:4] == MMIO_BASE[31:4];
    assign d_mi_sel = d_win && (dmemreq_addr[3:0] == 4'h4);
    assign mo_wr    = dmemreq_val && dmemreq_type && d_win && (dmemreq_addr[3:0] == 4'h0);

    // MMIO output register with a one-cycle update strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mmio_out     <= '0;
            mmio_out_val <= 1'b0;
        end else begin
            mmio_out_val <= mo_wr;
            if (mo_wr) mmio_out <= dmemreq_wdata;
        end
    end
`else
    logic unused_mmio;

    assign i_win        = 1'b0;
    assign d_win        = 1'b0;
    assign d_mi_sel     = 1'b0;
    assign mmio_out     = '0;
    assign mmio_out_val = 1'b0;
    assign unused_mmio  = ^{mmio_in, MMIO_BASE};
`endif

    assign i_legal = i_ok && !i_win;
    assign d_legal = d_ok && !d_win;
    // MMIO-window dmem accesses never flag an error, even unmapped offsets.
    assign i_bad   = imemreq_val && !i_legal;
    assign d_bad   = dmemreq_val && !d_win && !d_ok;
    assign d_wr    = dmemreq_val && dmemreq_type && d_legal && rst;

    // Fetch data; zero for idle cycles and illegal addresses
    always_comb begin
        i_rd0 = '0;
        if (imemreq_val && i_legal) i_rd0 = mem[i_idx];
    end

    // Load data; writes and illegal/unmapped reads answer with zero
    always_comb begin
        d_rd0 = '0;
        if (dmemreq_val && !dmemreq_type) begin
            if (d_mi_sel)     d_rd0 = mmio_in;
            else if (d_legal) d_rd0 = mem[d_idx];
        end
    end

    // Array write; the imem read above sees the old word in the same cycle
    always_ff @(posedge clk) begin
        if (d_wr) mem[d_idx] <= dmemreq_wdata;
    end

    // Response pipelines: stage 1 is loaded at the accepting edge, stage LAT drives the port
    logic [LAT:1]       i_vld_pipe, d_vld_pipe;
    logic [LAT:1][31:0] i_dat_pipe, d_dat_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_vld_pipe <= '0;
            d_vld_pipe <= '0;
            i_dat_pipe <= '0;
            d_dat_pipe <= '0;
        end else begin
            for (int s = LAT; s > 1; s--) begin
                i_vld_pipe[s] <= i_vld_pipe[s-1];
                d_vld_pipe[s] <= d_vld_pipe[s-1];
                i_dat_pipe[s] <= i_dat_pipe[s-1];
                d_dat_pipe[s] <= d_dat_pipe[s-1];
            end
            i_vld_pipe[1] <= imemreq_val;
            d_vld_pipe[1] <= dmemreq_val;
            i_dat_pipe[1] <= i_rd0;
            d_dat_pipe[1] <= d_rd0;
        end
    end

    // Sticky access-error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               err <= 1'b0;
        else if (i_bad || d_bad) err <= 1'b1;
    end

    // Data stages are already zero whenever their valid bit is zero
    assign imemresp_val   = i_vld_pipe[LAT];
    assign imemresp_rdata = i_dat_pipe[LAT];
    assign dmemresp_val   = d_vld_pipe[LAT];
    assign dmemresp_rdata = d_dat_pipe[LAT];

endmodule

// File: tb/tb_proc_mem_responder.sv
// Testbench for proc_mem_responder: three instances (LAT=1,2,3) share one stimulus stream.
// A word-array model computes each request's response; a small history ring delays it by
// each instance's latency. Directed table entries carry their own expected data.
module tb_proc_mem_responder;
    localparam int          WORDS = 64;
    localparam int          NI    = 3;
    localparam logic [31:0] MB    = 32'h0001_0000;
`ifdef MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif
    localparam logic [31:0] MI_RD = MMIO ? 32'h99 : 32'h0;

    typedef struct {
        bit          iv;
        logic [31:0] ia;
        bit          dv;
        bit          dt;
        logic [31:0] da;
        logic [31:0] wd;
        logic [31:0] mi;
        logic [31:0] ei;
        logic [31:0] ed;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        iv = 1'b0, dv = 1'b0, dt = 1'b0;
    logic [31:0] ia = '0, da = '0, wd = '0, mi = '0;
    logic        irv [NI], drv [NI], mov [NI], er [NI];
    logic [31:0] ird [NI], drd [NI], mo [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        proc_mem_responder #(.WORDS(WORDS), .LAT(g + 1), .MMIO_BASE(MB)) u_dut (
            .clk(clk), .rst(rst),
            .imemreq_val(iv), .imemreq_addr(ia),
            .imemresp_val(irv[g]), .imemresp_rdata(ird[g]),
            .dmemreq_val(dv), .dmemreq_type(dt), .dmemreq_addr(da), .dmemreq_wdata(wd),
            .dmemresp_val(drv[g]), .dmemresp_rdata(drd[g]),
            .mmio_in(mi), .mmio_out(mo[g]), .mmio_out_val(mov[g]), .err(er[g])
        );
    end

    int vectors = 0;
    int miscompares = 0;
    int c = 0;

    // reference state
    logic [31:0] mdl [WORDS];
    bit          err_m = 1'b0;
    logic [31:0] mo_m = '0;
    bit          mov_m = 1'b0;
    bit          hv_i [8];
    bit          hv_d [8];
    logic [31:0] hd_i [8];
    logic [31:0] hd_d [8];

    task automatic cmp(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lat%0d step %0d: got %h want %h", nm, g + 1, c, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(WORDS * 4));
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return MMIO && (a >= MB) && (a < MB + 32'd16);
    endfunction

    function automatic vec_t mk(input bit v_iv, input logic [31:0] v_ia, input bit v_dv, input bit v_dt,
                                input logic [31:0] v_da, input logic [31:0] v_wd, input logic [31:0] v_mi,
                                input logic [31:0] v_ei, input logic [31:0] v_ed);
        vec_t v;
        v.iv = v_iv; v.ia = v_ia; v.dv = v_dv; v.dt = v_dt; v.da = v_da;
        v.wd = v_wd; v.mi = v_mi; v.ei = v_ei; v.ed = v_ed;
        return v;
    endfunction

    task automatic clear_hist();
        for (int k = 0; k < 8; k++) begin
            hv_i[k] = 1'b0; hv_d[k] = 1'b0; hd_i[k] = '0; hd_d[k] = '0;
        end
    endtask

    task automatic check_outs();
        for (int g = 0; g < NI; g++) begin
            int s;
            s = (c - (g + 1)) & 7;
            cmp("imem_val",     g, 32'(irv[g]), 32'(hv_i[s]));
            cmp("imem_rdata",   g, ird[g],      hd_i[s]);
            cmp("dmem_val",     g, 32'(drv[g]), 32'(hv_d[s]));
            cmp("dmem_rdata",   g, drd[g],      hd_d[s]);
            cmp("err",          g, 32'(er[g]),  32'(err_m));
            cmp("mmio_out",     g, mo[g],       mo_m);
            cmp("mmio_out_val", g, 32'(mov[g]), 32'(mov_m));
        end
    endtask

    // Called at a negedge: check current outputs, drive one request pair, update the model.
    task automatic step(input vec_t v, input bit use_tab);
        logic [31:0] ri, rd;
        check_outs();
        iv = v.iv; ia = v.ia; dv = v.dv; dt = v.dt; da = v.da; wd = v.wd; mi = v.mi;
        ri = '0; rd = '0; mov_m = 1'b0;
        if (v.iv) begin
            if (legal(v.ia) && !in_win(v.ia)) ri = mdl[int'(v.ia >> 2)];
            else                              err_m = 1'b1;
        end
        if (v.dv) begin
            if (in_win(v.da)) begin
                if (!v.dt && v.da == MB + 32'd4) rd = v.mi;
                if (v.dt && v.da == MB) begin mo_m = v.wd; mov_m = 1'b1; end
            end else if (!legal(v.da)) begin
                err_m = 1'b1;
            end else if (v.dt) begin
                mdl[int'(v.da >> 2)] = v.wd;
            end else begin
                rd = mdl[int'(v.da >> 2)];
            end
        end
        hv_i[c & 7] = v.iv;
        hv_d[c & 7] = v.dv;
        hd_i[c & 7] = use_tab ? v.ei : ri;
        hd_d[c & 7] = use_tab ? v.ed : rd;
        @(negedge clk);
        c++;
    endtask

    // Asynchronous reset asserted half a cycle after the last accepting edge.
    task automatic do_reset();
        check_outs();
        iv = 1'b0; dv = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            cmp("rst_imem_val",   g, 32'(irv[g]), 32'd0);
            cmp("rst_imem_rdata", g, ird[g],      32'd0);
            cmp("rst_dmem_val",   g, 32'(drv[g]), 32'd0);
            cmp("rst_dmem_rdata", g, drd[g],      32'd0);
            cmp("rst_err",        g, 32'(er[g]),  32'd0);
            cmp("rst_mmio_out",   g, mo[g],       32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_hist();
        err_m = 1'b0; mo_m = '0; mov_m = 1'b0;
        c++;
    endtask

    function automatic logic [31:0] raddr();
        int r;
        r = $urandom_range(0, 31);
        if (r < 26)  return 32'($urandom_range(0, WORDS - 1)) << 2;
        if (r == 26) return (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
        if (r == 27) return 32'(WORDS * 4) + (32'($urandom_range(0, 15)) << 2);
        if (r <= 29) return MB;
        if (r == 30) return MB + 32'd4;
        return MB + 32'd8;
    endfunction

    vec_t tab [18];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        //            iv ia      dv dt da         wd            mi     ei            ed
        tab[0]  = mk(0, 0,      1, 1, 32'h10,    32'hDEADBEEF, 0,     0,            0);
        tab[1]  = mk(0, 0,      1, 0, 32'h10,    0,            0,     0,            32'hDEADBEEF);
        tab[2]  = mk(0, 0,      1, 1, 32'h20,    32'h5,        0,     0,            0);
        tab[3]  = mk(0, 0,      1, 1, 32'h0,     32'h11,       0,     0,            0);
        tab[4]  = mk(0, 0,      1, 1, 32'h4,     32'h22,       0,     0,            0);
        tab[5]  = mk(0, 0,      1, 1, 32'h8,     32'h33,       0,     0,            0);
        tab[6]  = mk(1, 32'h20, 1, 1, 32'h20,    32'h1234,     0,     32'h5,        0);
        tab[7]  = mk(1, 32'h20, 0, 0, 0,         0,            0,     32'h1234,     0);
        tab[8]  = mk(1, 32'h0,  0, 0, 0,         0,            0,     32'h11,       0);
        tab[9]  = mk(1, 32'h4,  0, 0, 0,         0,            0,     32'h22,       0);
        tab[10] = mk(1, 32'h8,  0, 0, 0,         0,            0,     32'h33,       0);
        tab[11] = mk(0, 0,      1, 1, MB,        32'h42,       0,     0,            0);
        tab[12] = mk(0, 0,      1, 0, MB + 4,    0,            32'h99, 0,           MI_RD);
        tab[13] = mk(0, 0,      1, 0, MB + 8,    0,            32'h77, 0,           0);
        tab[14] = mk(0, 0,      1, 0, 32'h3,     0,            0,     0,            0);
        tab[15] = mk(0, 0,      1, 1, 32'(WORDS * 4), 32'hBAD, 0,     0,            0);
        tab[16] = mk(1, 32'h10, 1, 0, 32'h0,     0,            0,     32'hDEADBEEF, 32'h11);
        tab[17] = idle;

        clear_hist();
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            cmp("reset_imem_val", g, 32'(irv[g]), 32'd0);
            cmp("reset_dmem_val", g, 32'(drv[g]), 32'd0);
            cmp("reset_err",      g, 32'(er[g]),  32'd0);
            cmp("reset_mmio_val", g, 32'(mov[g]), 32'd0);
        end
        rst = 1'b1;

        // fill the array so every later read has a defined value
        for (int k = 0; k < WORDS; k++)
            step(mk(0, 0, 1, 1, 32'(k) << 2, $urandom, 0, 0, 0), 1'b0);

        for (int k = 0; k < 18; k++) step(tab[k], 1'b1);

        // two reads in flight, then reset: nothing may come out afterwards
        step(mk(1, 32'h0, 1, 0, 32'h10, 0, 0, 0, 0), 1'b0);
        step(mk(1, 32'h8, 1, 0, 32'h4,  0, 0, 0, 0), 1'b0);
        do_reset();
        repeat (4) step(idle, 1'b0);
        step(mk(1, 32'h20, 1, 0, 32'h10, 0, 0, 32'h1234, 32'hDEADBEEF), 1'b1);

        for (int k = 0; k < 500; k++) begin
            vec_t v;
            if (k == 250) do_reset();
            v = mk($urandom_range(0, 3) != 0, raddr(), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   raddr(), $urandom, $urandom, 0, 0);
            step(v, 1'b0);
        end
        repeat (5) step(idle, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
